count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Interval-timer controller that sequences the team's T-flip-flop ripple-enable up-counter.
//  Drives the counter's enable and active-low clear, watches its Q output, and flags terminal count.
//  Supports one-shot and auto-reload intervals with pause and stop.
//  Sits between the host control logic (start/stop/period) and one counter instance.
// PARAMETERS
//  WIDTH   16  counter / period width in bits
//  WRAP_W  8   width of the elapsed-interval counter wrap_count
// PORTS
//  clock       in   1       single system clock, all state updates on rising edge
//  clear       in   1       synchronous reset, active-high
//  start       in   1       accepted only in IDLE; latches period and mode
//  stop        in   1       abort current interval
//  pause       in   1       level; freezes counter while high in RUN
//  mode        in   1       0 = one-shot, 1 = auto-reload; latched on start
//  period      in   WIDTH   terminal value P; latched on start
//  cnt_q       in   WIDTH   Q from the counter
//  cnt_enable  out  1       counter enable
//  cnt_clear_n out  1       counter clear, active-low
//  busy        out  1       high in any state except IDLE
//  tick        out  1       one-cycle pulse, one per completed interval
//  done        out  1       one-cycle pulse, one-shot interval complete
//  wrap_count  out  WRAP_W  completed intervals since last start; saturates at all-ones
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset (clear=1 at an edge): state=IDLE; period_r, mode_r, tick, wrap_count = 0.
//   - cnt_clear_n = ~(clear | state==CLR), so the counter is also cleared while reset is high.
//   - Reset mid-operation: IDLE the next cycle; no tick or done pulse.
//  States (one-hot, registered): IDLE, CLR, RUN, HOLD, DONE.
//  Outputs decoded from state only (glitch-free):
//   - cnt_enable = RUN
//   - busy = !IDLE
//   - done = DONE
//  IDLE: enable=0, clear_n=1, so the counter holds its value.
//   - start & !stop: latch period_r/mode_r, wrap_count=0, go to CLR.
//   - start & stop in the same cycle: stay in IDLE.
//  CLR: exactly one cycle; clear_n=0; go to RUN (counter reads 0 on the first RUN cycle).
//  RUN, checks in priority order:
//   1. stop: go to IDLE.
//   2. cnt_q==period_r: match. Go to CLR if mode_r=1, otherwise DONE.
//   3. pause: go to HOLD.
//   4. Otherwise stay in RUN.
//  Match wins over a same-cycle pause.
//   - enable is high during the match cycle, so the counter shows P+1 for one cycle before CLR or DONE.
//  HOLD: enable=0. stop -> IDLE; !pause -> RUN; otherwise stay in HOLD.
//  DONE: one cycle, done=1; go to IDLE.
//  tick: registered; high in the cycle after a match, i.e. the first CLR or DONE cycle.
//  Interval timing:
//   - Interval length is P+2 cycles (P+1 counting cycles plus CLR).
//   - P=0 is legal: 2-cycle interval.
//   - P=2^WIDTH-1: counter wraps to 0 on the match edge; no special case.
//  wrap_count: +1 on each match, saturating at 2^WRAP_W-1.
//   - Cleared on reset and on an accepted start.
//   - Holds its value through stop and IDLE.
//  Ignored inputs:
//   - start while busy.
//   - period/mode changes while busy: they take effect only on the next accepted start.
//   - stop while in IDLE.
//  Stop: takes effect on the next edge; tick and done are not asserted; the counter keeps its value.
// TESTING
//  1. Reset, then start with P=3, mode=0 at cycle t0.
//     -> CLR at t1; RUN t2..t5 with cnt_q 0..3.
//     -> tick=done=1 at t6; IDLE at t7; busy high for exactly 6 cycles.
//  2. P=2, mode=1, run 13 cycles.
//     -> tick every 4 cycles; wrap_count 1,2,3; cnt_clear_n low one cycle per interval.
//  3. P=5, mode=0; hold pause high 5 cycles while cnt_q=1.
//     -> cnt_enable=0 and cnt_q stays 1 throughout.
//     -> done arrives 5 cycles later than without pause.
//  4. P=9; assert stop when cnt_q=2.
//     -> IDLE next cycle, cnt_q holds 3, no tick/done, wrap_count stays 0.
//     -> Start pulses while busy earlier in the run are ignored.
//  5. P=16'hFFFF, mode=1.
//     -> tick after 65537 cycles; cnt_q goes FFFF->0 on the match edge, then CLR.
//  6. clear=1 for 2 cycles mid-RUN.
//     -> cnt_clear_n=0 during clear; IDLE afterwards; wrap_count=0, tick=0.
//     -> The next start behaves as in scenario 1.

Source files
------------

// File: rtl/count_sequencer.sv
// Interval-timer controller for an external enable/clear up-counter: one-shot and auto-reload
// intervals with pause, stop, terminal-count tick and a saturating interval counter.
module count_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [WIDTH-1:0]  period,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              cnt_enable,
  output logic              cnt_clear_n,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_count
);

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StClr  = 5'b00010,
    StRun  = 5'b00100,
    StHold = 5'b01000,
    StDone = 5'b10000
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic               mode_q, mode_d;
  logic               tick_q, tick_d;
  logic [WRAP_W-1:0]  wrap_q, wrap_d;

  logic accept;
  logic match;

  assign accept = (state_q == StIdle) && start && !stop;
  // Stop outranks a terminal-count match in the same cycle.
  assign match  = (state_q == StRun) && !stop && (cnt_q == period_q);

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= StIdle;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      wrap_q   <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StClr;
      end
      StClr: begin
        state_d = StRun;
      end
      StRun: begin
        if (stop)       state_d = StIdle;
        else if (match) state_d = mode_q ? StClr : StDone;
        else if (pause) state_d = StHold;
        else            state_d = StRun;
      end
      StHold: begin
        if (stop)        state_d = StIdle;
        else if (!pause) state_d = StRun;
        else             state_d = StHold;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Latched configuration, tick and interval count
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    wrap_d   = wrap_q;
    tick_d   = match;
    if (accept) begin
      period_d = period;
      mode_d   = mode;
      wrap_d   = '0;
    end else if (match && (wrap_q != {WRAP_W{1'b1}})) begin
      wrap_d = wrap_q + 1'b1;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    cnt_enable  = (state_q == StRun);
    cnt_clear_n = ~(clear | (state_q == StClr));
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    tick        = tick_q;
    wrap_count  = wrap_q;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural enable/clear up-counter on cnt_q.
module tb_count_sequencer;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned WRAP_W = 8;

  logic              clock = 1'b0;
  logic              clear, start, stop, pause, mode;
  logic [WIDTH-1:0]  period;
  logic [WIDTH-1:0]  cnt_q = '0;
  logic              cnt_enable, cnt_clear_n, busy, tick, done;
  logic [WRAP_W-1:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  count_sequencer #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mode        (mode),
    .period      (period),
    .cnt_q       (cnt_q),
    .cnt_enable  (cnt_enable),
    .cnt_clear_n (cnt_clear_n),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .wrap_count  (wrap_count)
  );

  always #5 clock = ~clock;

  // Counter being sequenced
  always @(posedge clock) begin
    if (!cnt_clear_n)    cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; period = '0;
    cyc();
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL reset_wrap: got %0d want 0", wrap_count); end
    n_checks++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", cnt_enable); end
    n_checks++; if (cnt_clear_n !== 1'b0) begin n_fail++; $display("FAIL reset_clrn: got %b want 0", cnt_clear_n); end
    n_checks++; if (cnt_q !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_q); end
    clear = 1'b0;
    #1;
    n_checks++; if (cnt_clear_n !== 1'b1) begin n_fail++; $display("FAIL reset_clrn_rel: got %b want 1", cnt_clear_n); end
  endtask

  task automatic test_one_shot(input string tag);
    period = 16'd3; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; period = 16'h00AA; mode = 1'b1;  // must be ignored while busy
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_t1: got %b want 1", tag, busy); end
    n_checks++; if (cnt_clear_n !== 1'b0) begin n_fail++; $display("FAIL %s_clrn_t1: got %b want 0", tag, cnt_clear_n); end
    n_checks++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL %s_en_t1: got %b want 0", tag, cnt_enable); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (cnt_q !== 16'(i)) begin n_fail++; $display("FAIL %s_cnt_run: got %0d want %0d", tag, cnt_q, i); end
      n_checks++; if ({cnt_enable, busy, tick, done} !== 4'b1100) begin
        n_fail++; $display("FAIL %s_run_flags: got %b want 1100", tag, {cnt_enable, busy, tick, done});
      end
    end
    cyc();
    n_checks++; if ({cnt_enable, busy, tick, done} !== 4'b0111) begin
      n_fail++; $display("FAIL %s_done_flags: got %b want 0111", tag, {cnt_enable, busy, tick, done});
    end
    n_checks++; if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL %s_wrap: got %0d want 1", tag, wrap_count); end
    cyc();
    n_checks++; if ({busy, tick, done} !== 3'b000) begin
      n_fail++; $display("FAIL %s_idle_flags: got %b want 000", tag, {busy, tick, done});
    end
  endtask

  task automatic test_auto_reload();
    period = 16'd2; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) cyc();
      n_checks++; if (tick !== (k % 4 == 1 && k > 1)) begin
        n_fail++; $display("FAIL ar_tick k=%0d: got %b want %b", k, tick, (k % 4 == 1 && k > 1));
      end
      n_checks++; if (cnt_clear_n !== (k % 4 != 1)) begin
        n_fail++; $display("FAIL ar_clrn k=%0d: got %b want %b", k, cnt_clear_n, (k % 4 != 1));
      end
      n_checks++; if (wrap_count !== 8'((k - 1) / 4)) begin
        n_fail++; $display("FAIL ar_wrap k=%0d: got %0d want %0d", k, wrap_count, (k - 1) / 4);
      end
    end
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++; if ({busy, tick, done} !== 3'b000) begin
      n_fail++; $display("FAIL ar_stop_flags: got %b want 000", {busy, tick, done});
    end
    cyc();
    n_checks++; if (wrap_count !== 8'd3) begin n_fail++; $display("FAIL ar_wrap_hold: got %0d want 3", wrap_count); end
    n_checks++; if (cnt_q !== 16'd1) begin n_fail++; $display("FAIL ar_cnt_hold: got %0d want 1", cnt_q); end
  endtask

  task automatic test_pause();
    period = 16'd5; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL pz_wrap_start: got %0d want 0", wrap_count); end
    cyc();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if ({cnt_enable, busy} !== 2'b01 || cnt_q !== 16'd1) begin
        n_fail++; $display("FAIL pz_hold i=%0d: got en,busy=%b cnt=%0d want 01 cnt=1", i, {cnt_enable, busy}, cnt_q);
      end
    end
    pause = 1'b0;
    for (int t = 8; t <= 13; t++) begin
      cyc();
      n_checks++; if (done !== (t == 13)) begin
        n_fail++; $display("FAIL pz_done t=%0d: got %b want %b", t, done, (t == 13));
      end
    end
    cyc();
  endtask

  task automatic test_stop();
    period = 16'd9; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; period = 16'd1;  // start while busy must not relatch
    cyc();
    start = 1'b0;
    cyc();
    n_checks++; if (cnt_q !== 16'd2 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL st_ignore_start: got cnt=%0d done=%b busy=%b want cnt=2 done=0 busy=1", cnt_q, done, busy);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++; if ({busy, tick, done, cnt_enable} !== 4'b0000) begin
      n_fail++; $display("FAIL st_flags: got %b want 0000", {busy, tick, done, cnt_enable});
    end
    n_checks++; if (cnt_q !== 16'd3) begin n_fail++; $display("FAIL st_cnt: got %0d want 3", cnt_q); end
    n_checks++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL st_wrap: got %0d want 0", wrap_count); end
    stop = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b0 || cnt_q !== 16'd3) begin
      n_fail++; $display("FAIL st_idle_stop: got busy=%b cnt=%0d want busy=0 cnt=3", busy, cnt_q);
    end
    start = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || cnt_clear_n !== 1'b1) begin
      n_fail++; $display("FAIL st_start_stop: got busy=%b clrn=%b want busy=0 clrn=1", busy, cnt_clear_n);
    end
  endtask

  task automatic test_max_period();
    int k;
    logic [WIDTH-1:0] prev;
    period = 16'hFFFF; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    k = 1;
    prev = cnt_q;
    while (tick !== 1'b1 && k < 70000) begin
      prev = cnt_q;
      cyc();
      k++;
    end
    n_checks++; if (k !== 65538) begin n_fail++; $display("FAIL mx_tick_cycle: got %0d want 65538", k); end
    n_checks++; if (prev !== 16'hFFFF) begin n_fail++; $display("FAIL mx_prev_cnt: got %h want ffff", prev); end
    n_checks++; if (cnt_q !== 16'h0000 || cnt_clear_n !== 1'b0) begin
      n_fail++; $display("FAIL mx_wrap_edge: got cnt=%h clrn=%b want cnt=0000 clrn=0", cnt_q, cnt_clear_n);
    end
    n_checks++; if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL mx_wrap: got %0d want 1", wrap_count); end
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_saturate();
    period = 16'd0; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      cyc();
      n_checks++; if (tick !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL sat_tick k=%0d: got %b want %b", k, tick, (k % 2 == 1));
      end
    end
    repeat (600) cyc();
    n_checks++; if (wrap_count !== 8'hFF) begin n_fail++; $display("FAIL sat_wrap: got %0d want 255", wrap_count); end
    if (!cnt_enable) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || wrap_count !== 8'hFF) begin
      n_fail++; $display("FAIL sat_stop: got busy=%b wrap=%0d want busy=0 wrap=255", busy, wrap_count);
    end
  endtask

  task automatic test_clear_mid_run();
    period = 16'd2; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    n_checks++; if (wrap_count !== 8'd1 || cnt_enable !== 1'b1) begin
      n_fail++; $display("FAIL cl_pre: got wrap=%0d en=%b want wrap=1 en=1", wrap_count, cnt_enable);
    end
    clear = 1'b1;
    #1;
    n_checks++; if (cnt_clear_n !== 1'b0) begin n_fail++; $display("FAIL cl_clrn_now: got %b want 0", cnt_clear_n); end
    cyc();
    n_checks++; if ({busy, tick, done, cnt_clear_n} !== 4'b0000 || wrap_count !== 8'd0) begin
      n_fail++; $display("FAIL cl_during: got flags=%b wrap=%0d want 0000 wrap=0", {busy, tick, done, cnt_clear_n}, wrap_count);
    end
    cyc();
    clear = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || cnt_clear_n !== 1'b1 || cnt_q !== 16'd0) begin
      n_fail++; $display("FAIL cl_after: got busy=%b clrn=%b cnt=%0d want 0 1 0", busy, cnt_clear_n, cnt_q);
    end
    test_one_shot("cl_rerun");
  endtask

  initial begin
    test_reset();
    test_one_shot("os");
    test_auto_reload();
    test_pause();
    test_stop();
    test_saturate();
    test_clear_mid_run();
    test_max_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
